laser_shot_controller: RTL and testbench



---
 rtl/laser_shot_if.sv | 18 +
 rtl/laser_shot_controller.sv | 114 +++++++++++
 tb/tb_laser_shot_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/laser_shot_if.sv
// laser_shot_if: fire/ship/alien inputs and shot/score outputs of the laser shot controller.
// The slave modport is the controller side; the master modport is the driving side.
interface laser_shot_if;
  logic       fire;
  logic [9:0] ship_x, ship_y, alien_x, alien_y;
  logic       alien_active;
  logic [9:0] o_shot_x, o_shot_y;
  logic       shot_active, hit_detected;
  logic [15:0] score;
  modport master (
    output fire, ship_x, ship_y, alien_x, alien_y, alien_active,
    input  o_shot_x, o_shot_y, shot_active, hit_detected, score
  );
  modport slave (
    input  fire, ship_x, ship_y, alien_x, alien_y, alien_active,
    output o_shot_x, o_shot_y, shot_active, hit_detected, score
  );
endinterface

// File: rtl/laser_shot_controller.sv
// laser_shot_controller: single player laser shot with alien collision, hit pulse and saturating score.
// Optional AUTOFIRE_EN: a held fire level re-launches after each cooldown instead of needing a fresh edge.
module laser_shot_controller #(
  parameter int SHOT_SPEED      = 250000,
  parameter int SHOT_STEP       = 2,
  parameter int X_MAX           = 774,
  parameter int SHIP_NOSE_X     = 24,
  parameter int SHIP_MID_Y      = 8,
  parameter int SHOT_W          = 8,
  parameter int SHOT_H          = 2,
  parameter int ALIEN_W         = 32,
  parameter int ALIEN_H         = 32,
  parameter int COOLDOWN_CYCLES = 5000000,
  parameter logic [15:0] SCORE_MAX = 16'hFFFF
) (
  input logic        clk,
  input logic        reset_n,
  laser_shot_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FLY, HIT, COOLDOWN} state_t;
  localparam logic [10:0] SW = 11'(SHOT_W);
  localparam logic [10:0] SH = 11'(SHOT_H);
  localparam logic [10:0] AW = 11'(ALIEN_W);
  localparam logic [10:0] AH = 11'(ALIEN_H);
  localparam logic [10:0] ST = 11'(SHOT_STEP);
  localparam logic [10:0] XM = 11'(X_MAX);
  state_t      state_q, state_d;
  logic        s1_q, s2_q, d_q;
  logic [31:0] cnt_q, cnt_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        act_q, act_d, hit_q, hit_d;
  logic [15:0] score_q, score_d;
  logic        launch, step_due, collide;
  logic [10:0] sx, sy, ax, ay;
`ifdef AUTOFIRE_EN
  assign launch = s2_q;
`else
  assign launch = s2_q & ~d_q;
`endif
  assign sx = {1'b0, x_q};
  assign sy = {1'b0, y_q};
  assign ax = {1'b0, bus.alien_x};
  assign ay = {1'b0, bus.alien_y};
  assign step_due = cnt_q == 32'(SHOT_SPEED - 1);
  // 11-bit sums keep the box overlap test free of wrap-around near the 10-bit limit
  assign collide = bus.alien_active & (sx + SW > ax) & (sx < ax + AW) & (sy + SH > ay) & (sy < ay + AH);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    act_d   = act_q;
    hit_d   = 1'b0;
    score_d = score_q;
    case (state_q)
      IDLE: if (launch) begin
        state_d = FLY;
        x_d     = bus.ship_x + 10'(SHIP_NOSE_X);
        y_d     = bus.ship_y + 10'(SHIP_MID_Y);
        act_d   = 1'b1;
        cnt_d   = '0;
      end
      FLY: if (collide) begin
        state_d = HIT;
        hit_d   = 1'b1;
        act_d   = 1'b0;
        cnt_d   = '0;
        score_d = score_q == SCORE_MAX ? score_q : score_q + 16'd1;
      end else if (step_due) begin
        cnt_d = '0;
        if (sx + ST > XM) begin
          state_d = COOLDOWN;
          act_d   = 1'b0;
        end else x_d = x_q + 10'(SHOT_STEP);
      end else cnt_d = cnt_q + 32'd1;
      HIT: state_d = COOLDOWN;
      COOLDOWN: if (cnt_q == 32'(COOLDOWN_CYCLES)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 32'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      d_q     <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      act_q   <= 1'b0;
      hit_q   <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= bus.fire;
      s2_q    <= s1_q;
      d_q     <= s2_q;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      act_q   <= act_d;
      hit_q   <= hit_d;
      score_q <= score_d;
    end
  end
  assign bus.o_shot_x     = x_q;
  assign bus.o_shot_y     = y_q;
  assign bus.shot_active  = act_q;
  assign bus.hit_detected = hit_q;
  assign bus.score        = score_q;
endmodule

// File: tb/tb_laser_shot_controller.sv
// tb_laser_shot_controller: randomized stimulus, behavioural shot model feeding an expected-output queue,
// and an independent monitor that pops one expectation per clock. Honours AUTOFIRE_EN like the design.
module tb_laser_shot_controller;
  localparam int SPEED = 4, STEP = 2, COOL = 8, XMAX = 774;
  localparam logic [15:0] SMAX = 16'd3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  laser_shot_if bus ();
  laser_shot_controller #(
    .SHOT_SPEED(SPEED), .SHOT_STEP(STEP), .COOLDOWN_CYCLES(COOL), .SCORE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;

  typedef struct {bit act; int x; int y; bit hit; int score;} snap_t;
  snap_t expq[$];
  int errors = 0, checks = 0;

  // model: fire level seen at the last three clock edges, plus the shot's life story
  bit f1, f2, f3, flying, just_hit, mhit;
  int mx, my, age, rest, mscore;

  task automatic model_reset();
    f1 = 0; f2 = 0; f3 = 0; flying = 0; just_hit = 0; mhit = 0;
    mx = 0; my = 0; age = 0; rest = -1; mscore = 0;
    expq.delete();
  endtask

  task automatic model_tick();
    bit trig;
    int ax, ay;
`ifdef AUTOFIRE_EN
    trig = f2;
`else
    trig = f2 && !f3;
`endif
    ax = int'(bus.alien_x);
    ay = int'(bus.alien_y);
    mhit = 0;
    if (just_hit) begin
      just_hit = 0;
      rest = 0;
    end else if (rest >= 0) rest = (rest == COOL) ? -1 : rest + 1;
    else if (flying) begin
      if (bus.alien_active && mx + 8 > ax && mx < ax + 32 && my + 2 > ay && my < ay + 32) begin
        flying = 0; just_hit = 1; mhit = 1;
        if (mscore < int'(SMAX)) mscore++;
      end else if (age % SPEED == SPEED - 1) begin
        if (mx + STEP > XMAX) begin
          flying = 0; rest = 0;
        end else mx += STEP;
      end
      age++;
    end else if (trig) begin
      flying = 1; age = 0;
      mx = int'(bus.ship_x) + 24;
      my = int'(bus.ship_y) + 8;
    end
    f3 = f2; f2 = f1; f1 = bus.fire;
    expq.push_back(snap_t'{flying, mx, my, mhit, mscore});
  endtask

  task automatic check_zero(string name);
    checks++;
    if (bus.shot_active !== 1'b0 || bus.hit_detected !== 1'b0 || bus.o_shot_x !== 10'd0 ||
        bus.o_shot_y !== 10'd0 || bus.score !== 16'd0) begin
      errors++;
      $display("FAIL %s t=%0t got act=%b hit=%b x=%0d y=%0d score=%0d want all zero",
               name, $time, bus.shot_active, bus.hit_detected, bus.o_shot_x, bus.o_shot_y, bus.score);
    end
  endtask

  // monitor: every clock the DUT presents one output snapshot to be matched
  snap_t e;
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset_n) check_zero("reset_state");
    else if (expq.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_cycle t=%0t no expectation queued", $time);
    end else begin
      e = expq.pop_front();
      checks++;
      if (bus.shot_active !== e.act || int'(bus.o_shot_x) != e.x || int'(bus.o_shot_y) != e.y ||
          bus.hit_detected !== e.hit || int'(bus.score) != e.score) begin
        errors++;
        $display("FAIL cycle_check t=%0t got act=%b x=%0d y=%0d hit=%b score=%0d want act=%0d x=%0d y=%0d hit=%0d score=%0d",
                 $time, bus.shot_active, bus.o_shot_x, bus.o_shot_y, bus.hit_detected, bus.score,
                 e.act, e.x, e.y, e.hit, e.score);
      end
    end
  end

  task automatic cyc();
    model_tick();
    @(negedge clk);
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic fire_press(int n);
    bus.fire = 1'b1;
    run(n);
    bus.fire = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1 check_zero("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic place(int sx, int sy, int ax, int ay, bit act);
    bus.ship_x = 10'(sx); bus.ship_y = 10'(sy);
    bus.alien_x = 10'(ax); bus.alien_y = 10'(ay);
    bus.alien_active = act;
  endtask

  initial begin
    model_reset();
    bus.fire = 1'b0;
    place(100, 200, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // launch, then abort mid-flight with reset
    fire_press(2);
    run(30);
    do_reset();
    // full flight to the right edge, no alien
    fire_press(1);
    run(1340);
    // hit at x=134 against alien at (140,200)
    place(100, 200, 140, 200, 1'b1);
    fire_press(1);
    run(40);
    // same geometry with alien inactive, then it wakes up mid-overlap
    bus.alien_active = 1'b0;
    fire_press(1);
    run(60);
    bus.alien_active = 1'b1;
    run(30);
    // fire edges during flight and cooldown are dropped
    fire_press(1);
    run(8);
    fire_press(1);
    run(16);
    fire_press(1);
    run(3);
    fire_press(2);
    run(30);
    // held fire with alien sitting on the launch point: score saturates
    place(100, 200, 124, 208, 1'b1);
    bus.fire = 1'b1;
    run(200);
    bus.fire = 1'b0;
    run(20);
    // collision raised exactly on the edge-exit step: hit must win
    place(100, 200, 770, 200, 1'b0);
    fire_press(1);
    for (int i = 0; i < 1500 && (flying || i < 4); i++) begin
      bus.alien_active = flying && mx == XMAX && age % SPEED == SPEED - 1;
      cyc();
    end
    bus.alien_active = 1'b0;
    run(20);
    // randomized episodes from a fresh score
    do_reset();
    for (int ep = 0; ep < 40; ep++) begin
      int sx, sy, ax, ay;
      sx = $urandom_range(0, 600);
      sy = $urandom_range(40, 900);
      ax = sx + 24 + $urandom_range(0, 150);
      ay = sy + 8 - $urandom_range(0, 40);
      place(sx, sy, ax, ay, $urandom_range(0, 3) != 0);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 7) == 0) bus.fire = ~bus.fire;
        if ($urandom_range(0, 31) == 0) bus.alien_active = ~bus.alien_active;
        cyc();
      end
    end
    bus.fire = 1'b0;
    bus.alien_active = 1'b0;
    run(60);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
